mc_rsp_merge: RTL and testbench

Response-side crossbar merge for the AE memory path, on the same MC interface the request FIFO drives. Accepts read responses from the eight memory controllers, buffers each in a per-MC lane FIFO and applies a per-lane high-watermark stall. A round-robin arbiter merges the lanes into one registered, valid/ready response stream for the AE datapath. Also reports idle status and lane overflow/underflow alarms.

---
 rtl/mc_rsp_pkg.sv | 24 ++
 rtl/mc_rsp_lane.sv | 59 +++++
 rtl/mc_rsp_merge.sv | 141 ++++++++++++++
 tb/tb_mc_rsp_merge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_rsp_pkg.sv
// Shared types and the round-robin pick helper for the MC response merge.
package mc_rsp_pkg;

    localparam int NMC     = 8;
    localparam int RCW_DEF = 32;

    typedef struct packed {
        logic [RCW_DEF-1:0] rdctl;
        logic [63:0]        data;
    } rsp_ent_t;

    // Returns {hit, idx}; scanning offsets high-to-low lets the nearest lane to ptr win last.
    function automatic logic [3:0] rr_pick(input logic [NMC-1:0] req, input logic [2:0] ptr);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int i = NMC - 1; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/mc_rsp_lane.sv
// One MC response lane: synchronous FIFO with occupancy count and registered high-watermark flag.
module mc_rsp_lane #(
    parameter int DEPTH  = 16,
    parameter int WMTHLD = 10,
    parameter int W      = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_hiwm
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
    localparam logic [AW:0] HIV   = (AW+1)'(WMTHLD);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_hiwm;
    logic          w_rd;
    logic [AW:0]   w_count_nxt;

    // The caller gates i_wr against full, so only the read side needs guarding here.
    assign w_rd        = i_pop & ~o_empty;
    assign w_count_nxt = r_count + {{AW{1'b0}}, i_wr} - {{AW{1'b0}}, w_rd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hiwm  <= 1'b0;
        end else begin
            if (i_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_hiwm  <= (w_count_nxt >= HIV);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wptr] <= i_din;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULLV);
    assign o_empty = (r_count == '0);
    assign o_hiwm  = r_hiwm;

endmodule

// File: rtl/mc_rsp_merge.sv
// Merges eight MC response lanes into one registered valid/ready stream (round-robin).
// Define RSPMERGE_ALARM_EN to build overflow/underflow alarm detection; otherwise alarms tie low.
module mc_rsp_merge
    import mc_rsp_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WMTHLD = 10,
    parameter int RCW    = 32
) (
    input  logic               clk167,
    input  logic               reset167,
    input  logic [NMC-1:0]     mc_rsp_push,
    input  logic [NMC*RCW-1:0] mc_rsp_rdctl,
    input  logic [NMC*64-1:0]  mc_rsp_data,
    output logic [NMC-1:0]     mc_rsp_stall,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_mc,
    output logic [RCW-1:0]     rsp_rdctl,
    output logic [63:0]        rsp_data,
    output logic               rsp_idle,
    output logic               r_ovrflow_alarm,
    output logic               r_undflow_alarm
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = RCW + 64;

    logic [EW-1:0]  w_head  [NMC];
    logic [CW-1:0]  w_count [NMC];
    logic [NMC-1:0] w_full;
    logic [NMC-1:0] w_empty;
    logic [NMC-1:0] w_wr;
    logic [NMC-1:0] w_pop;
    logic [NMC-1:0] w_zero_nxt;
    logic [3:0]     w_pick;
    logic           w_hit;
    logic [2:0]     w_idx;
    logic           w_load;
    logic           w_grant;
    logic           w_valid_nxt;

    logic           r_valid;
    logic [2:0]     r_mc;
    logic [RCW-1:0] r_rdctl;
    logic [63:0]    r_data;
    logic [2:0]     r_ptr;
    logic           r_idle;

    assign w_pick      = rr_pick(~w_empty, r_ptr);
    assign w_hit       = w_pick[3];
    assign w_idx       = w_pick[2:0];
    assign w_load      = ~r_valid | rsp_ready;
    assign w_grant     = w_load & w_hit;
    assign w_valid_nxt = w_load ? w_hit : r_valid;

    for (genvar k = 0; k < NMC; k++) begin : g_lane
        assign w_pop[k] = w_grant & (w_idx == 3'(k));
        // Full is judged after this cycle's pop, so a push alongside a pop is never dropped.
        assign w_wr[k]  = mc_rsp_push[k] & (~w_full[k] | w_pop[k]);
        assign w_zero_nxt[k] = ((w_count[k] == '0) & ~w_wr[k]) |
                               ((w_count[k] == CW'(1)) & w_pop[k] & ~w_wr[k]);

        mc_rsp_lane #(
            .DEPTH  (DEPTH),
            .WMTHLD (WMTHLD),
            .W      (EW)
        ) u_lane (
            .clk     (clk167),
            .rst     (reset167),
            .i_wr    (w_wr[k]),
            .i_din   ({mc_rsp_rdctl[k*RCW +: RCW], mc_rsp_data[k*64 +: 64]}),
            .i_pop   (w_pop[k]),
            .o_head  (w_head[k]),
            .o_count (w_count[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k]),
            .o_hiwm  (mc_rsp_stall[k])
        );
    end

    // Output stage: fields hold while the consumer stalls; an idle load only clears valid.
    always_ff @(posedge clk167 or posedge reset167) begin
        if (reset167) begin
            r_valid <= 1'b0;
            r_mc    <= '0;
            r_rdctl <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
            r_idle  <= 1'b1;
        end else begin
            if (w_load) begin
                r_valid <= w_hit;
                if (w_hit) begin
                    r_mc              <= w_idx;
                    {r_rdctl, r_data} <= w_head[w_idx];
                    r_ptr             <= w_idx + 3'd1;
                end
            end
            r_idle <= (&w_zero_nxt) & ~w_valid_nxt;
        end
    end

    always_comb begin
        assert (!(w_grant && w_empty[w_idx]));
    end

    assign rsp_valid = r_valid;
    assign rsp_mc    = r_mc;
    assign rsp_rdctl = r_rdctl;
    assign rsp_data  = r_data;
    assign rsp_idle  = r_idle;

`ifdef RSPMERGE_ALARM_EN
    logic c_ovrflow;
    logic c_undflow;
    logic r_ovf_q;
    logic r_udf_q;

    always_ff @(posedge clk167 or posedge reset167) begin
        if (reset167) begin
            c_ovrflow <= 1'b0;
            c_undflow <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_udf_q   <= 1'b0;
        end else begin
            c_ovrflow <= |(mc_rsp_push & ~w_wr);
            c_undflow <= w_grant & w_empty[w_idx];
            r_ovf_q   <= r_ovf_q | c_ovrflow;
            r_udf_q   <= r_udf_q | c_undflow;
        end
    end

    assign r_ovrflow_alarm = r_ovf_q;
    assign r_undflow_alarm = r_udf_q;
`else
    assign r_ovrflow_alarm = 1'b0;
    assign r_undflow_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_mc_rsp_merge.sv
// Directed testbench for mc_rsp_merge: single response, fairness, backpressure, watermark, overflow, reset.
module tb_mc_rsp_merge;

    logic         clk167;
    logic         reset167;
    logic [7:0]   mc_rsp_push;
    logic [255:0] mc_rsp_rdctl;
    logic [511:0] mc_rsp_data;
    logic [7:0]   mc_rsp_stall;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [2:0]   rsp_mc;
    logic [31:0]  rsp_rdctl;
    logic [63:0]  rsp_data;
    logic         rsp_idle;
    logic         r_ovrflow_alarm;
    logic         r_undflow_alarm;

    int ntest = 0;
    int nfail = 0;

`ifdef RSPMERGE_ALARM_EN
    logic exp_ovf = 1'b1;
`else
    logic exp_ovf = 1'b0;
`endif

    mc_rsp_merge dut (
        .clk167          (clk167),
        .reset167        (reset167),
        .mc_rsp_push     (mc_rsp_push),
        .mc_rsp_rdctl    (mc_rsp_rdctl),
        .mc_rsp_data     (mc_rsp_data),
        .mc_rsp_stall    (mc_rsp_stall),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_mc          (rsp_mc),
        .rsp_rdctl       (rsp_rdctl),
        .rsp_data        (rsp_data),
        .rsp_idle        (rsp_idle),
        .r_ovrflow_alarm (r_ovrflow_alarm),
        .r_undflow_alarm (r_undflow_alarm)
    );

    initial begin
        clk167 = 1'b0;
        forever #5 clk167 = ~clk167;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk167);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic [31:0] rd, input logic [63:0] d);
        mc_rsp_push[k]            = 1'b1;
        mc_rsp_rdctl[k*32 +: 32]  = rd;
        mc_rsp_data[k*64 +: 64]   = d;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] mc, input logic [63:0] d);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_mc"},    64'(rsp_mc), 64'(mc));
        chk({tag, "_data"},  rsp_data, d);
    endtask

    initial begin
        reset167     = 1'b1;
        mc_rsp_push  = '0;
        mc_rsp_rdctl = '0;
        mc_rsp_data  = '0;
        rsp_ready    = 1'b1;
        #2;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mc",    64'(rsp_mc), 64'd0);
        chk("rst_rdctl", 64'(rsp_rdctl), 64'd0);
        chk("rst_data",  rsp_data, 64'd0);
        chk("rst_stall", 64'(mc_rsp_stall), 64'd0);
        chk("rst_idle",  64'(rsp_idle), 64'd1);
        chk("rst_ovf",   64'(r_ovrflow_alarm), 64'd0);
        chk("rst_udf",   64'(r_undflow_alarm), 64'd0);
        tick();
        tick();
        reset167 = 1'b0;

        // Single response on mc3
        drive(3, 32'h55, 64'hA5A5);
        tick();
        mc_rsp_push = '0;
        chk("single_early_valid", 64'(rsp_valid), 64'd0);
        chk("single_busy_idle",   64'(rsp_idle), 64'd0);
        tick();
        chk_out("single", 3'd3, 64'hA5A5);
        chk("single_rdctl", 64'(rsp_rdctl), 64'h55);
        tick();
        chk("single_done_valid", 64'(rsp_valid), 64'd0);
        chk("single_done_idle",  64'(rsp_idle), 64'd1);

        // Fairness from rr_ptr = 0
        reset167 = 1'b1;
        tick();
        reset167 = 1'b0;
        for (int k = 0; k < 8; k++) drive(k, 32'h10 + 32'(k), 64'h1000 + 64'(k));
        tick();
        mc_rsp_push = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("fair%0d", i), 3'(i), 64'h1000 + 64'(i));
            chk($sformatf("fair%0d_rdctl", i), 64'(rsp_rdctl), 64'h10 + 64'(i));
        end
        drive(2, 32'h22, 64'h2002);
        drive(6, 32'h66, 64'h2006);
        tick();
        mc_rsp_push = '0;
        chk("fair_gap_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk_out("fair_b0", 3'd2, 64'h2002);
        tick();
        chk_out("fair_b1", 3'd6, 64'h2006);
        tick();
        chk("fair_end_valid", 64'(rsp_valid), 64'd0);
        chk("fair_end_idle",  64'(rsp_idle), 64'd1);

        // Backpressure: rr_ptr is 7, lanes 1 and 4 pending
        rsp_ready = 1'b0;
        drive(1, 32'h31, 64'h3001);
        drive(4, 32'h34, 64'h3004);
        tick();
        mc_rsp_push = '0;
        tick();
        chk_out("bp_first", 3'd1, 64'h3001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp_hold%0d", i), 3'd1, 64'h3001);
        end
        rsp_ready = 1'b1;
        tick();
        chk_out("bp_next", 3'd4, 64'h3004);
        tick();
        chk("bp_end_valid", 64'(rsp_valid), 64'd0);

        // Watermark on lane 5 with the output register occupied by lane 0
        rsp_ready = 1'b0;
        drive(0, 32'h40, 64'h4000);
        tick();
        mc_rsp_push = '0;
        tick();
        chk_out("wm_hold", 3'd0, 64'h4000);
        for (int i = 0; i < 10; i++) begin
            drive(5, 32'h50 + 32'(i), 64'h5000 + 64'(i));
            tick();
            chk($sformatf("wm_stall_push%0d", i + 1), 64'(mc_rsp_stall[5]), (i == 9) ? 64'd1 : 64'd0);
        end
        mc_rsp_push = '0;
        tick();
        chk("wm_stall_held", 64'(mc_rsp_stall[5]), 64'd1);
        rsp_ready = 1'b1;
        tick();
        chk("wm_stall_drop", 64'(mc_rsp_stall[5]), 64'd0);
        chk_out("wm_drain0", 3'd5, 64'h5000);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk_out($sformatf("wm_drain%0d", i), 3'd5, 64'h5000 + 64'(i));
        end
        tick();
        chk("wm_end_valid", 64'(rsp_valid), 64'd0);

        // Overflow: lane 7 parks in the output, then 17 pushes into lane 0
        rsp_ready = 1'b0;
        drive(7, 32'h77, 64'h7777);
        tick();
        mc_rsp_push = '0;
        tick();
        chk_out("ovf_park", 3'd7, 64'h7777);
        for (int i = 0; i < 17; i++) begin
            drive(0, 32'h60 + 32'(i), 64'h6000 + 64'(i));
            tick();
        end
        mc_rsp_push = '0;
        tick();
        chk("ovf_alarm", 64'(r_ovrflow_alarm), 64'(exp_ovf));
        chk("ovf_udf",   64'(r_undflow_alarm), 64'd0);
        chk("ovf_stall", 64'(mc_rsp_stall[0]), 64'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_out($sformatf("ovf_drain%0d", i), 3'd0, 64'h6000 + 64'(i));
        end
        tick();
        chk("ovf_end_valid", 64'(rsp_valid), 64'd0);
        chk("ovf_end_idle",  64'(rsp_idle), 64'd1);
        chk("ovf_sticky",    64'(r_ovrflow_alarm), 64'(exp_ovf));

        // Reset mid-stream with four lanes occupied
        rsp_ready = 1'b0;
        for (int k = 0; k < 8; k += 2) drive(k, 32'h80 + 32'(k), 64'h8000 + 64'(k));
        tick();
        mc_rsp_push = '0;
        tick();
        chk_out("mrst_pre", 3'd2, 64'h8002);
        reset167 = 1'b1;
        #2;
        chk("mrst_valid", 64'(rsp_valid), 64'd0);
        chk("mrst_mc",    64'(rsp_mc), 64'd0);
        chk("mrst_rdctl", 64'(rsp_rdctl), 64'd0);
        chk("mrst_data",  rsp_data, 64'd0);
        chk("mrst_idle",  64'(rsp_idle), 64'd1);
        chk("mrst_ovf",   64'(r_ovrflow_alarm), 64'd0);
        tick();
        reset167  = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mrst_after%0d_valid", i), 64'(rsp_valid), 64'd0);
            chk($sformatf("mrst_after%0d_idle", i),  64'(rsp_idle), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
